// File: rtl/mp_adder_pkg.sv
// Shared types and helpers for the sequential multi-precision adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mp_adder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ovf_add(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder32.sv
// One-word ripple adder with carry in/out, shared across all words of an operand.
// Latency: combinational.
// Backpressure: none.
module adder32 #(
    parameter int DATA_WIDTH = 31
) (
    input  logic [DATA_WIDTH:0] a,
    input  logic [DATA_WIDTH:0] b,
    input  logic                cin,
    output logic [DATA_WIDTH:0] s,
    output logic                cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, 1'b0, cin};

endmodule

// File: rtl/mp_adder_seq.sv
// Wide add/sub streamed LSW-first through one adder32, carry chained in a register.
// Latency: WORDS cycles from acceptance to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module mp_adder_seq
    import mp_adder_pkg::*;
#(
    parameter int WORDS      = 4,
    parameter int DATA_WIDTH = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_a,
    input  logic [WORDS*WORD_W-1:0] in_b,
    input  logic                    in_cin,
    input  logic                    in_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_sum,
    output logic                    out_cout,
    output logic                    out_ovf
);

    localparam int              IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int              W    = WORDS * WORD_W;
    localparam logic [IW-1:0]   LAST = IW'(WORDS - 1);

    state_t              state;
    logic [W-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic [W-1:0]        sum_q;
    logic                carry;
    logic [IW-1:0]       idx;
    logic [DATA_WIDTH:0] add_s;
    logic                add_cout;

    // Word 0 of the shift registers is always the word being added.
    adder32 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_adder32 (
        .a   (a_sh[WORD_W-1:0]),
        .b   (b_sh[WORD_W-1:0]),
        .cin (carry),
        .s   (add_s),
        .cout(add_cout)
    );

    assign in_ready = (state == IDLE);
    assign out_sum  = sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_q     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + ~borrow_in.
                        a_sh  <= in_a;
                        b_sh  <= in_sub ? ~in_b : in_b;
                        carry <= in_sub ? ~in_cin : in_cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx*WORD_W +: WORD_W] <= add_s;
                    carry <= add_cout;
                    a_sh  <= a_sh >> WORD_W;
                    b_sh  <= b_sh >> WORD_W;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_cout  <= add_cout;
                        out_ovf   <= ovf_add(a_sh[WORD_W-1], b_sh[WORD_W-1], add_s[DATA_WIDTH]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_adder_seq.sv
// Directed bench for mp_adder_seq (WORDS=4): carries, borrows, overflow, backpressure, reset abort.
module tb_mp_adder_seq;
    import mp_adder_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = WORDS * WORD_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;

    mp_adder_seq #(
        .WORDS     (WORDS),
        .DATA_WIDTH(31)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle and let it be taken on the next edge.
    task automatic accept(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_b({tag, "_in_ready"}, in_ready, 1'b1);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles from acceptance to out_valid, bounded.
    task automatic wait_out(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_i({tag, "_latency"}, lat, WORDS);
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] sum, input logic cout,
                              input logic ovf);
        check_b({tag, "_valid"}, out_valid, 1'b1);
        check_w({tag, "_sum"}, out_sum, sum);
        check_b({tag, "_cout"}, out_cout, cout);
        check_b({tag, "_ovf"}, out_ovf, ovf);
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_b({tag, "_pop_valid"}, out_valid, 1'b0);
        check_b({tag, "_pop_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] ones;
        ones      = {WORDS{32'hFFFF_FFFF}};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_b("rst_in_ready", in_ready, 1'b1);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_w("rst_out_sum", out_sum, '0);
        check_b("rst_out_cout", out_cout, 1'b0);
        check_b("rst_out_ovf", out_ovf, 1'b0);

        // 1: carry ripples through every word
        accept("t1", ones, 128'h1, 1'b0, 1'b0);
        check_b("t1_busy", in_ready, 1'b0);
        wait_out("t1");
        expect_res("t1", '0, 1'b1, 1'b0);
        pop("t1");

        // 2: carry-in ripples across word boundaries into word 3
        accept("t2", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, '0, 1'b0, 1'b1);
        wait_out("t2");
        expect_res("t2", 128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
        pop("t2");

        // 3: subtraction with and without borrow
        accept("t3a", 128'h5, 128'h7, 1'b1, 1'b0);
        wait_out("t3a");
        expect_res("t3a", 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
        pop("t3a");
        accept("t3b", 128'h7, 128'h5, 1'b1, 1'b0);
        wait_out("t3b");
        expect_res("t3b", 128'h2, 1'b1, 1'b0);
        pop("t3b");

        // 4: signed overflow
        accept("t4", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0);
        wait_out("t4");
        expect_res("t4", 128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);
        pop("t4");

        // 5: backpressure while a second bundle waits at the input
        accept("t5", 128'h1, 128'h2, 1'b0, 1'b0);
        in_a     = 128'h10;
        in_b     = 128'h20;
        in_sub   = 1'b0;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        wait_out("t5");
        for (int i = 0; i < 10; i++) begin
            check_w("t5_hold_sum", out_sum, 128'h3);
            check_b("t5_hold_valid", out_valid, 1'b1);
            check_b("t5_hold_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_b("t5_idle_valid", out_valid, 1'b0);
        check_b("t5_idle_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_b("t5_taken", in_ready, 1'b0);
        wait_out("t5b");
        expect_res("t5b", 128'h30, 1'b0, 1'b0);
        pop("t5b");

        // 6: reset two edges into RUN aborts the operation
        accept("t6", ones, ones, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_b("t6_rst_valid", out_valid, 1'b0);
        check_w("t6_rst_sum", out_sum, '0);
        check_b("t6_rst_in_ready", in_ready, 1'b1);
        accept("t6b", 128'h3, 128'h4, 1'b0, 1'b0);
        wait_out("t6b");
        expect_res("t6b", 128'h7, 1'b0, 1'b0);
        pop("t6b");

        // Reset coinciding with a handshake: nothing is accepted
        in_a     = 128'h9;
        in_b     = 128'h9;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_b("rst_hs_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check_b("rst_hs_no_result", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
